// File: rtl/fft_out_reorder_if.sv
// Streaming port bundle for fft_out_reorder: bit-reversed input stream in,
// natural-order output stream plus partial-frame error pulse out.
interface fft_out_reorder_if #(
    parameter int unsigned DW = 16
);
    logic                 valid_in;
    logic                 sop_in;
    logic                 inv_in;
    logic signed [DW-1:0] d_re;
    logic signed [DW-1:0] d_im;
    logic                 valid_out;
    logic                 sop_out;
    logic signed [DW-1:0] y_re;
    logic signed [DW-1:0] y_im;
    logic                 sop_err;

    modport master (
        output valid_in, sop_in, inv_in, d_re, d_im,
        input  valid_out, sop_out, y_re, y_im, sop_err
    );

    modport slave (
        input  valid_in, sop_in, inv_in, d_re, d_im,
        output valid_out, sop_out, y_re, y_im, sop_err
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed 256-point FFT results in, natural order out.
// Define FFT_OUT_INV_SCALE_EN to apply 1/N (>>> 8) scaling to frames tagged inv.
module fft_out_reorder #(
    parameter int unsigned N  = 256,
    parameter int unsigned DW = 16
) (
    input logic               clk,
    input logic               rst_n,
    fft_out_reorder_if.slave  bus
);
    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] LastIdx = AW'(N - 1);

`ifdef FFT_OUT_INV_SCALE_EN
    localparam logic ScaleEn = 1'b1;
`else
    localparam logic ScaleEn = 1'b0;
`endif

    typedef enum logic {WIdle, WFill} wstate_e;
    typedef enum logic {RIdle, RRead} rstate_e;

    function automatic logic [AW-1:0] bitrev8(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    logic signed [DW-1:0] mem_re [2*N];
    logic signed [DW-1:0] mem_im [2*N];

    wstate_e       wstate_q, wstate_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          wbank_q, wbank_d;
    logic [1:0]    tag_q, tag_d;
    logic          err_d;
    logic          we, wr_done;
    logic [AW:0]   waddr;

    rstate_e       rstate_q, rstate_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic          rbank_q, rbank_d;
    logic [1:0]    full_q, full_d;
    logic          rd_en, rd_last;
    logic [AW:0]   raddr;

    logic                 rd_valid_q, rd_sop_q, rd_inv_q;
    logic signed [DW-1:0] rd_re_q, rd_im_q;
    logic signed [DW-1:0] sc_re, sc_im;
    logic                 valid_out_q, sop_out_q, sop_err_q;
    logic signed [DW-1:0] y_re_q, y_im_q;

    // Write side: a sop always (re)starts the frame at slot 0 of the current bank.
    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        tag_d    = tag_q;
        err_d    = 1'b0;
        we       = 1'b0;
        wr_done  = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                if (bus.valid_in && bus.sop_in) begin
                    we             = 1'b1;
                    tag_d[wbank_q] = bus.inv_in;
                    wcnt_d         = 8'd1;
                    wstate_d       = WFill;
                end
            end
            WFill: begin
                if (bus.valid_in) begin
                    we = 1'b1;
                    if (bus.sop_in) begin
                        err_d          = (wcnt_q != '0);
                        tag_d[wbank_q] = bus.inv_in;
                        wcnt_d         = 8'd1;
                    end else if (wcnt_q == LastIdx) begin
                        wr_done  = 1'b1;
                        wcnt_d   = '0;
                        wbank_d  = ~wbank_q;
                        wstate_d = WIdle;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    assign waddr = {wbank_q, (bus.sop_in ? 8'd0 : bitrev8(wcnt_q))};

    // Read side: flags are resolved first so a bank completing this cycle avoids a bubble.
    always_comb begin
        rd_en   = (rstate_q == RRead);
        rd_last = rd_en && (rcnt_q == LastIdx);
        full_d  = full_q;
        if (wr_done) full_d[wbank_q] = 1'b1;
        if (rd_last) full_d[rbank_q] = 1'b0;
        rbank_d  = rd_last ? ~rbank_q : rbank_q;
        rcnt_d   = rd_en ? rcnt_q + 8'd1 : rcnt_q;
        rstate_d = full_d[rbank_d] ? RRead : RIdle;
    end

    assign raddr = {rbank_q, rcnt_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q <= WIdle;
            wcnt_q   <= '0;
            wbank_q  <= 1'b0;
            tag_q    <= '0;
            rstate_q <= RIdle;
            rcnt_q   <= '0;
            rbank_q  <= 1'b0;
            full_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            wbank_q  <= wbank_d;
            tag_q    <= tag_d;
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            rbank_q  <= rbank_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_re[waddr] <= bus.d_re;
            mem_im[waddr] <= bus.d_im;
        end
        if (rd_en) begin
            rd_re_q <= mem_re[raddr];
            rd_im_q <= mem_im[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_sop_q   <= 1'b0;
            rd_inv_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_sop_q   <= rd_en && (rcnt_q == '0);
            rd_inv_q   <= tag_q[rbank_q];
        end
    end

    always_comb begin
        sc_re = rd_re_q;
        sc_im = rd_im_q;
        if (ScaleEn && rd_inv_q) begin
            sc_re = rd_re_q >>> 8;
            sc_im = rd_im_q >>> 8;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out_q <= 1'b0;
            sop_out_q   <= 1'b0;
            sop_err_q   <= 1'b0;
            y_re_q      <= '0;
            y_im_q      <= '0;
        end else begin
            valid_out_q <= rd_valid_q;
            sop_out_q   <= rd_sop_q;
            sop_err_q   <= err_d;
            if (rd_valid_q) begin
                y_re_q <= sc_re;
                y_im_q <= sc_im;
            end
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.sop_out   = sop_out_q;
    assign bus.sop_err   = sop_err_q;
    assign bus.y_re      = y_re_q;
    assign bus.y_im      = y_im_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized self-checking bench for fft_out_reorder against a natural-order
// reference model built from the bit-reversed arrival order.
module tb_fft_out_reorder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_out_reorder_if #(.DW(16)) bus ();

    fft_out_reorder #(.N(256), .DW(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    int oq_re[$];
    int oq_im[$];
    bit oq_sop[$];
    int oq_cyc[$];
    int eq_cyc[$];

    logic signed [15:0] stim_re[0:1023];
    logic signed [15:0] stim_im[0:1023];
    int exp_re[0:1023];
    int exp_im[0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            oq_re.push_back(int'(bus.y_re));
            oq_im.push_back(int'(bus.y_im));
            oq_sop.push_back(bus.sop_out);
            oq_cyc.push_back(cyc);
        end
        if (bus.sop_err === 1'b1) eq_cyc.push_back(cyc);
    end

    function automatic int bitrev(input int a);
        int r = 0;
        for (int i = 0; i < 8; i++) if (((a >> i) & 1) == 1) r = r | (1 << (7 - i));
        return r;
    endfunction

    // 1/N normalisation = floor division by 256
    function automatic int ref_scale(input int d, input bit inv);
`ifdef FFT_OUT_INV_SCALE_EN
        if (inv) return (d >= 0) ? d / 256 : -((-d + 255) / 256);
`endif
        return d;
    endfunction

    function automatic void make_exp(input int base, input bit inv);
        for (int n = 0; n < 256; n++) begin
            exp_re[base + n] = ref_scale(int'(stim_re[base + bitrev(n)]), inv);
            exp_im[base + n] = ref_scale(int'(stim_im[base + bitrev(n)]), inv);
        end
    endfunction

    // Number of output samples disagreeing with the model (value, sop, contiguity).
    function automatic int frame_bad(input int n);
        int bad = 0;
        if (oq_re.size() < n) return n;
        for (int i = 0; i < n; i++) begin
            if (oq_re[i] != exp_re[i] || oq_im[i] != exp_im[i]) bad++;
            else if (oq_sop[i] != ((i % 256) == 0)) bad++;
            else if (oq_cyc[i] != oq_cyc[0] + i) bad++;
        end
        return bad;
    endfunction

    task automatic send(input bit s, input bit inv, input int re, input int im);
        bus.valid_in = 1'b1;
        bus.sop_in   = s;
        bus.inv_in   = inv;
        bus.d_re     = 16'(re);
        bus.d_im     = 16'(im);
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        oq_re.delete();
        oq_im.delete();
        oq_sop.delete();
        oq_cyc.delete();
        eq_cyc.delete();
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int t = 0;
        while (oq_re.size() < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        ok = (oq_re.size() >= n);
        idle(8);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_out got %b want 0", bus.valid_out);
        end
        checks++;
        if (bus.sop_out !== 1'b0 || bus.sop_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_sop got sop_out=%b sop_err=%b want 0/0", bus.sop_out, bus.sop_err);
        end
        checks++;
        if (bus.y_re !== 16'sd0 || bus.y_im !== 16'sd0) begin
            errors++;
            $display("FAIL reset_y got %0d/%0d want 0/0", bus.y_re, bus.y_im);
        end
        // valid without sop while idle must be dropped silently
        clear_q();
        send(1'b0, 1'b0, 5, 5);
        idle(20);
        checks++;
        if (oq_re.size() != 0 || eq_cyc.size() != 0) begin
            errors++;
            $display("FAIL stray_sample got outputs=%0d errs=%0d want 0/0", oq_re.size(),
                     eq_cyc.size());
        end
    endtask

    task automatic test_single(input string nm, input bit gaps);
        bit ok;
        int acc;
        clear_q();
        for (int k = 0; k < 256; k++) begin
            stim_re[k] = 16'(k);
            stim_im[k] = 16'(-k);
        end
        make_exp(0, 1'b0);
        for (int k = 0; k < 256; k++) begin
            send(k == 0, 1'b0, k, -k);
            acc = last_acc;
            if (gaps) idle(1);
        end
        idle(0);
        wait_out(256, 1000, ok);
        checks++;
        if (!ok || oq_re.size() != 256) begin
            errors++;
            $display("FAIL %s_count got %0d want 256", nm, oq_re.size());
        end
        checks++;
        if (frame_bad(256) != 0) begin
            errors++;
            $display("FAIL %s_data got %0d bad samples want 0", nm, frame_bad(256));
        end
        if (oq_re.size() >= 256) begin
            checks++;
            if (oq_cyc[0] != acc + 2) begin
                errors++;
                $display("FAIL %s_latency got cycle %0d want %0d", nm, oq_cyc[0], acc + 2);
            end
            checks++;
            if (oq_re[1] != 128 || oq_re[3] != 192 || oq_re[255] != 255 || oq_im[1] != -128) begin
                errors++;
                $display("FAIL %s_spot got %0d/%0d/%0d/%0d want 128/192/255/-128", nm,
                         oq_re[1], oq_re[3], oq_re[255], oq_im[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_q();
        for (int i = 0; i < 768; i++) begin
            stim_re[i] = 16'($urandom);
            stim_im[i] = 16'($urandom);
        end
        for (int f = 0; f < 3; f++) make_exp(f * 256, 1'b0);
        for (int i = 0; i < 768; i++) send((i % 256) == 0, 1'b0, stim_re[i], stim_im[i]);
        idle(0);
        wait_out(768, 2000, ok);
        checks++;
        if (!ok || oq_re.size() != 768) begin
            errors++;
            $display("FAIL b2b_count got %0d want 768", oq_re.size());
        end
        checks++;
        if (frame_bad(768) != 0) begin
            errors++;
            $display("FAIL b2b_data got %0d bad samples want 0", frame_bad(768));
        end
        if (oq_re.size() >= 768) begin
            checks++;
            if (oq_sop[256] != 1'b1 || oq_sop[512] != 1'b1 || oq_cyc[767] - oq_cyc[0] != 767) begin
                errors++;
                $display("FAIL b2b_sop_span got sop=%b/%b span=%0d want 1/1/767", oq_sop[256],
                         oq_sop[512], oq_cyc[767] - oq_cyc[0]);
            end
        end
    endtask

    task automatic test_sop_err();
        bit ok;
        int err_acc = 0;
        clear_q();
        for (int k = 0; k < 256; k++) begin
            stim_re[k] = 16'($urandom);
            stim_im[k] = 16'($urandom);
        end
        make_exp(0, 1'b0);
        for (int k = 0; k < 100; k++) send(k == 0, 1'b0, int'($urandom), int'($urandom));
        for (int k = 0; k < 256; k++) begin
            send(k == 0, 1'b0, stim_re[k], stim_im[k]);
            if (k == 0) err_acc = last_acc;
        end
        idle(0);
        wait_out(256, 1000, ok);
        checks++;
        if (eq_cyc.size() != 1) begin
            errors++;
            $display("FAIL sop_err_count got %0d want 1", eq_cyc.size());
        end else begin
            checks++;
            if (eq_cyc[0] != err_acc) begin
                errors++;
                $display("FAIL sop_err_time got cycle %0d want %0d", eq_cyc[0], err_acc);
            end
        end
        checks++;
        if (!ok || oq_re.size() != 256 || frame_bad(256) != 0) begin
            errors++;
            $display("FAIL sop_err_frame got count=%0d bad=%0d want 256/0", oq_re.size(),
                     frame_bad(256));
        end
    endtask

    task automatic test_scale();
        bit ok;
        int want;
        for (int v = 0; v < 2; v++) begin
            bit inv = (v == 0);
            clear_q();
            for (int k = 0; k < 256; k++) begin
                stim_re[k] = -16'sd300;
                stim_im[k] = 16'($urandom);
            end
            make_exp(0, inv);
`ifdef FFT_OUT_INV_SCALE_EN
            want = inv ? -2 : -300;
`else
            want = -300;
`endif
            for (int k = 0; k < 256; k++) send(k == 0, inv, stim_re[k], stim_im[k]);
            idle(0);
            wait_out(256, 1000, ok);
            checks++;
            if (!ok || frame_bad(256) != 0) begin
                errors++;
                $display("FAIL scale_inv%0d_data got %0d bad samples want 0", inv, frame_bad(256));
            end
            checks++;
            if (oq_re.size() == 0 || oq_re[0] != want) begin
                errors++;
                $display("FAIL scale_inv%0d_re got %0d want %0d", inv,
                         (oq_re.size() == 0) ? 0 : oq_re[0], want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int n0;
        clear_q();
        for (int k = 0; k < 256; k++) begin
            stim_re[k] = 16'($urandom);
            stim_im[k] = 16'($urandom);
        end
        for (int k = 0; k < 256; k++) send(k == 0, 1'b0, stim_re[k], stim_im[k]);
        idle(0);
        while (oq_re.size() < 50 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (oq_re.size() < 50) begin
            errors++;
            $display("FAIL rst_mid_reach got %0d outputs want 50", oq_re.size());
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid got %b want 0", bus.valid_out);
        end
        n0 = oq_re.size();
        idle(300);
        checks++;
        if (oq_re.size() != n0) begin
            errors++;
            $display("FAIL rst_mid_quiet got %0d extra outputs want 0", oq_re.size() - n0);
        end
        test_single("after_rst", 1'b0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.inv_in   = 1'b0;
        bus.d_re     = '0;
        bus.d_im     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_single("single", 1'b0);
        test_back_to_back();
        test_sop_err();
        test_single("gaps", 1'b1);
        test_scale();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output-side reorder buffer for the 256-point FFT. It accepts the FFT core's result stream, which arrives in bit-reversed index order, and re-emits each 256-sample frame in natural order on the same valid/sop streaming interface the FFT input uses. Two 256-entry banks operate ping-pong, so frames can arrive back-to-back and leave back-to-back. It sits between the last butterfly stage and the block's `valid_out/sop_out/y_re/y_im` outputs.

## Interface
- `N`, 256, frame length; fixed, and the bit-reverse is 8 bits wide.
- `DW`, 16, sample width in bits, signed two's complement.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `valid_in` in 1: input sample valid.
- `sop_in` in 1: first sample of a frame; qualified by `valid_in`.
- `inv_in` in 1: frame is an IFFT result; sampled only with `valid_in & sop_in`.
- `d_re`, `d_im` in DW: result sample, bit-reversed order.
- `valid_out` out 1: output sample valid.
- `sop_out` out 1: first natural-order sample (index 0) of a frame.
- `y_re`, `y_im` out DW: output sample, natural order.
- `sop_err` out 1: one-cycle pulse when a partial frame is discarded.

## Operation
**Write side**
- States are `W_IDLE` and `W_FILL`, with an 8-bit counter `wcnt`.
- `W_IDLE`:
  - `valid_in & sop_in`: write at `wcnt = 0`, latch `inv_in` into the bank's tag, go to `W_FILL`.
  - `valid_in` without sop: sample dropped, no error.
- `W_FILL`:
  - Each `valid_in` writes the bank at address `bitrev8(wcnt)`, then increments `wcnt`.
  - `valid_in & sop_in` with `wcnt != 0`: the partial frame is discarded and `sop_err` pulses. This sample restarts the frame at `wcnt = 0` in the same bank.
- After the write at `wcnt = 255`:
  - The bank is marked full and the write bank toggles.
  - State returns to `W_IDLE` with `wcnt = 0`.
- Gaps in `valid_in` (valid low) mid-frame are allowed and simply pause the write.

**Read side**
- States are `R_IDLE` and `R_READ`, with an 8-bit counter `rcnt`.
- `R_IDLE` → `R_READ` when the read bank is full.
- `R_READ` reads address `rcnt` on every cycle, with no stalls.
- At `rcnt = 255`:
  - The bank is marked empty and the read bank toggles.
  - If the other bank is already full, or becomes full in the same cycle, `R_READ` continues with no bubble.
  - Otherwise the state goes to `R_IDLE`.
- Overflow is impossible: the reader drains 1 sample/cycle and the writer fills at most 1 sample/cycle. No backpressure port exists.
- Simultaneous events:
  - The writer completing a bank in the same cycle the reader empties the other bank is legal.
  - The full/empty flags update independently per bank.

**Arithmetic**
- Data passes through unchanged, apart from the optional scaling under Configuration.

## Timing
- Reset values:
  - `valid_out = 0`, `sop_out = 0`, `y_re = 0`, `y_im = 0`, `sop_err = 0`.
  - Both banks empty, both state machines in IDLE, counters 0.
  - RAM contents are not reset.
- Latency: the first `valid_out`/`sop_out` is asserted 2 cycles after the edge that accepts the 256th input sample. The 2 cycles are one for the RAM read and one for the output register.
- Output frame: exactly 256 consecutive `valid_out` cycles.
  - `sop_out` is high only on the first of them.
  - `y_re/y_im` are held at their last value when `valid_out = 0`.
- `sop_err` pulses in the cycle after the offending `sop_in` is accepted.
- Reset mid-operation: the partial input frame and any pending or full banks are dropped. `valid_out` is low on the cycle after the reset edge.

## Configuration
- Macro: `FFT_OUT_INV_SCALE_EN`.
- Defined: frames tagged `inv = 1` output `y = d >>> 8`, an arithmetic right shift implementing IFFT 1/N normalisation. The shift floors toward −inf. Frames tagged `inv = 0` pass unchanged.
- Undefined: all frames pass unchanged, and `inv_in` is ignored. The tag register is still allowed to exist.
- Latency is identical in both builds.

## Test plan
- Single frame, `d_re = k` for arrival index k, `d_im = −k` → natural-order output n gives `y_re = bitrev8(n)` and `y_im = −bitrev8(n)`.
  - n = 1 gives 128; n = 3 gives 192; n = 255 gives 255.
  - `sop_out` rises exactly 2 cycles after the 256th sample is accepted.
- Three frames back-to-back with `valid_in` held high → 768 consecutive `valid_out` cycles with `sop_out` at cycles 0, 256 and 512, and no bubbles.
- Second `sop_in` at wcnt = 100 → `sop_err` pulses once, the first 100 samples are never output, and the restarted frame outputs correctly.
- `valid_in` toggled 1-0 across a frame → output identical to the single-frame case. The frame starts 2 cycles after the last accepted sample.
- With `FFT_OUT_INV_SCALE_EN`: `inv_in = 1`, all samples `d_re = −300` → every `y_re = −2`. With `inv_in = 0` and `d_re = −300` → `y_re = −300`.
- `rst_n` low for 1 cycle mid-output (rcnt = 50) → `valid_out = 0` on the next cycle, nothing further is output, and a fresh frame afterwards behaves as in the first scenario.
